// File: rtl/ula_seq_if.sv
// ula_seq_if: operand/result bus of the sequential ALU with master/slave views
//   start  : request, taken only while ocupado=0
//   sel    : operation select
//   a, b   : W-bit unsigned operands
//   saida  : 2W-bit registered result
//   carry, zero, divzero : status flags of the last completed op
//   ocupado: iterative op in progress
//   pronto : one-cycle pulse when saida/flags were just written
interface ula_seq_if #(parameter int W = 4);
  logic           start;
  logic [3:0]     sel;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] saida;
  logic           carry;
  logic           zero;
  logic           divzero;
  logic           ocupado;
  logic           pronto;
  modport master (output start, sel, a, b,
                  input  saida, carry, zero, divzero, ocupado, pronto);
  modport slave  (input  start, sel, a, b,
                  output saida, carry, zero, divzero, ocupado, pronto);
endinterface

// File: rtl/ula_seq.sv
// ula_seq: registered W-bit ALU, 16 ops, iterative multiply/divide, start/ocupado/pronto handshake
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : ula_seq_if slave view (start, sel, a, b in; saida, flags, ocupado, pronto out)
module ula_seq #(
  parameter int W = 4
) (
  input logic      clk,
  input logic      reset_n,
  ula_seq_if.slave bus
);
  localparam int CW = $clog2(W + 1);
  typedef enum logic {OCIOSO, CALC} state_t;
  state_t         state, state_n;
  logic [3:0]     op_sel;
  logic [W-1:0]   op_a, op_b;
  logic           pend;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc, mcand;
  logic [W-1:0]   q;
  logic [2*W-1:0] saida_q;
  logic           carry_q, zero_q, divzero_q, pronto_q;
  logic           accept, iter, last, is_mul;
  logic [W:0]     sum, dif;
  logic [2*W-1:0] s_res;
  logic           s_c;
  logic [2*W-1:0] mul_n, it_acc, it_res;
  logic [W:0]     r_sh, r_n;
  logic           ge;
  logic [W-1:0]   q_n;
  // Requests are only looked at while idle; a divide by zero is answered in one cycle.
  assign accept = bus.start && (state == OCIOSO);
  assign iter   = (bus.sel == 4'b0010) || ((bus.sel == 4'b0011) && (bus.b != '0));
  assign last   = cnt == CW'(W - 1);
  assign is_mul = !op_sel[0];
  always_comb begin
    state_n = (state == OCIOSO) ? ((accept && iter) ? CALC : OCIOSO)
                                : (last ? OCIOSO : CALC);
  end
  assign sum = {1'b0, op_a} + {1'b0, op_b};
  assign dif = {1'b0, op_a} - {1'b0, op_b};
  // One-cycle ops work on the latched operands; dif[W] is the borrow.
  always_comb begin
    s_res = '0;
    s_c   = 1'b0;
    case (op_sel)
      4'h0: begin s_res = (2*W)'(sum); s_c = sum[W]; end
      4'h1: begin s_res = (2*W)'(dif[W-1:0]); s_c = dif[W]; end
      4'h3: s_res = '1;
      4'h4: {s_c, s_res[W-1:0]} = {op_a, 1'b0};
      4'h5: {s_res[W-1:0], s_c} = {1'b0, op_a};
      4'h6: s_res[W-1:0] = {op_a[0], op_a[W-1:1]};
      4'h7: s_res[W-1:0] = {op_a[W-2:0], op_a[W-1]};
      4'h8: s_res[W-1:0] = op_a & op_b;
      4'h9: s_res[W-1:0] = op_a | op_b;
      4'hA: s_res[W-1:0] = op_a ^ op_b;
      4'hB: s_res[W-1:0] = ~(op_a & op_b);
      4'hC: s_res[W-1:0] = ~(op_a | op_b);
      4'hD: s_res[W-1:0] = ~(op_a ^ op_b);
      4'hE: s_res[0] = op_a > op_b;
      4'hF: s_res[0] = op_a == op_b;
      default: ;
    endcase
  end
  // Multiply: acc accumulates mcand (a shifted left) whenever the low multiplier bit in q is set.
  // Divide: acc holds the partial remainder, q shifts the dividend out and the quotient in.
  assign mul_n  = acc + (q[0] ? mcand : '0);
  assign r_sh   = {acc[W-1:0], q[W-1]};
  assign ge     = r_sh >= {1'b0, op_b};
  assign r_n    = ge ? r_sh - {1'b0, op_b} : r_sh;
  assign q_n    = {q[W-2:0], ge};
  assign it_acc = is_mul ? mul_n : (2*W)'(r_n);
  assign it_res = is_mul ? mul_n : {r_n[W-1:0], q_n};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= OCIOSO;
      pend      <= 1'b0;
      cnt       <= '0;
      op_sel    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      acc       <= '0;
      mcand     <= '0;
      q         <= '0;
      saida_q   <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b1;
      divzero_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      state    <= state_n;
      pend     <= accept && !iter;
      pronto_q <= 1'b0;
      if (accept) begin
        op_sel <= bus.sel;
        op_a   <= bus.a;
        op_b   <= bus.b;
        acc    <= '0;
        mcand  <= (2*W)'(bus.a);
        q      <= bus.sel[0] ? bus.a : bus.b;
        cnt    <= '0;
      end else if (state == CALC) begin
        acc   <= it_acc;
        mcand <= mcand << 1;
        q     <= is_mul ? q >> 1 : q_n;
        cnt   <= cnt + 1'b1;
      end
      if (pend) begin
        saida_q   <= s_res;
        carry_q   <= s_c;
        zero_q    <= s_res == '0;
        divzero_q <= op_sel == 4'h3;
        pronto_q  <= 1'b1;
      end else if ((state == CALC) && last) begin
        saida_q   <= it_res;
        carry_q   <= 1'b0;
        zero_q    <= it_res == '0;
        divzero_q <= 1'b0;
        pronto_q  <= 1'b1;
      end
    end
  end
  assign bus.saida   = saida_q;
  assign bus.carry   = carry_q;
  assign bus.zero    = zero_q;
  assign bus.divzero = divzero_q;
  assign bus.pronto  = pronto_q;
  assign bus.ocupado = state == CALC;
endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: checks ula_seq at W=4 and W=8 against an arithmetic reference model
module tb_ula_seq;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  ula_seq_if #(.W(4)) b4 ();
  ula_seq_if #(.W(8)) b8 ();
  ula_seq #(.W(4)) u4 (.clk(clk), .reset_n(reset_n), .bus(b4.slave));
  ula_seq #(.W(8)) u8 (.clk(clk), .reset_n(reset_n), .bus(b8.slave));
  logic       st[2];
  logic [3:0] sl[2];
  logic [7:0] av[2], bv[2];
  assign b4.start = st[0];
  assign b4.sel   = sl[0];
  assign b4.a     = av[0][3:0];
  assign b4.b     = bv[0][3:0];
  assign b8.start = st[1];
  assign b8.sel   = sl[1];
  assign b8.a     = av[1];
  assign b8.b     = bv[1];
  logic [15:0] o_s[2];
  logic        o_c[2], o_z[2], o_d[2], o_o[2], o_p[2];
  assign o_s[0] = 16'(b4.saida);
  assign o_c[0] = b4.carry;
  assign o_z[0] = b4.zero;
  assign o_d[0] = b4.divzero;
  assign o_o[0] = b4.ocupado;
  assign o_p[0] = b4.pronto;
  assign o_s[1] = b8.saida;
  assign o_c[1] = b8.carry;
  assign o_z[1] = b8.zero;
  assign o_d[1] = b8.divzero;
  assign o_o[1] = b8.ocupado;
  assign o_p[1] = b8.pronto;
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  function automatic int wd(input int i);
    return (i == 0) ? 4 : 8;
  endfunction
  function automatic logic [7:0] msk(input int i);
    return (i == 0) ? 8'h0F : 8'hFF;
  endfunction
  function automatic void calc(input int w, input logic [3:0] s, input logic [7:0] a8, input logic [7:0] b8_,
                               output logic [15:0] r, output logic c, output logic d);
    longint a, b, m, x;
    a = longint'(a8);
    b = longint'(b8_);
    m = (longint'(1) << w) - 1;
    x = 0;
    c = 1'b0;
    d = 1'b0;
    case (s)
      4'd0:  begin x = a + b; c = ((x >> w) & 1) != 0; end
      4'd1:  begin x = (a - b) & m; c = a < b; end
      4'd2:  x = a * b;
      4'd3:  if (b == 0) begin x = (longint'(1) << (2 * w)) - 1; d = 1'b1; end
             else x = ((a % b) << w) | (a / b);
      4'd4:  begin x = (a << 1) & m; c = ((a >> (w - 1)) & 1) != 0; end
      4'd5:  begin x = a >> 1; c = (a & 1) != 0; end
      4'd6:  x = (a >> 1) | ((a & 1) << (w - 1));
      4'd7:  x = ((a << 1) & m) | (a >> (w - 1));
      4'd8:  x = a & b;
      4'd9:  x = a | b;
      4'd10: x = a ^ b;
      4'd11: x = ~(a & b) & m;
      4'd12: x = ~(a | b) & m;
      4'd13: x = ~(a ^ b) & m;
      4'd14: x = longint'(a > b);
      default: x = longint'(a == b);
    endcase
    r = 16'(x);
  endfunction
  // Reference model: an op accepted while idle is due after 1 edge (W edges if iterative).
  logic [15:0] e_s[2], q_s[2];
  logic        e_c[2], e_z[2], e_d[2], e_o[2], e_p[2], q_c[2], q_d[2];
  int          left[2];
  always @(posedge clk or negedge reset_n) begin : model
    int nl;
    logic [15:0] ns, rr;
    logic nc, nd, nz, no, npl, rc, rd;
    logic [7:0] ma, mb;
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        e_s[i] <= '0; e_c[i] <= 1'b0; e_z[i] <= 1'b1; e_d[i] <= 1'b0;
        e_o[i] <= 1'b0; e_p[i] <= 1'b0; left[i] <= 0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
        nl = left[i]; ns = e_s[i]; nc = e_c[i]; nd = e_d[i]; nz = e_z[i]; no = e_o[i]; npl = 1'b0;
        if (nl > 0) begin
          nl = nl - 1;
          if (nl == 0) begin
            ns = q_s[i]; nc = q_c[i]; nd = q_d[i]; nz = (ns == 16'd0); npl = 1'b1; no = 1'b0;
          end
        end
        if (st[i] && !e_o[i]) begin
          ma = av[i] & msk(i);
          mb = bv[i] & msk(i);
          calc(wd(i), sl[i], ma, mb, rr, rc, rd);
          q_s[i] <= rr; q_c[i] <= rc; q_d[i] <= rd;
          no = (sl[i] == 4'd2) || ((sl[i] == 4'd3) && (mb != 8'd0));
          nl = no ? wd(i) : 1;
        end
        e_s[i] <= ns; e_c[i] <= nc; e_d[i] <= nd; e_z[i] <= nz; e_o[i] <= no; e_p[i] <= npl; left[i] <= nl;
      end
    end
  end
  // Hand-computed literal expectations, each tied to the cycle number it applies to.
  int          np = 0;
  int          pa[64], pi_[64], pf[64];
  logic [15:0] pv[64];
  string       fname[6] = '{"saida", "carry", "zero", "divzero", "ocupado", "pronto"};
  task automatic pin(input int i, input int f, input logic [15:0] v, input int at);
    pi_[np] = i; pf[np] = f; pv[np] = v; pa[np] = at;
    np++;
  endtask
  function automatic logic [15:0] getf(input int i, input int f);
    case (f)
      0: return o_s[i];
      1: return 16'(o_c[i]);
      2: return 16'(o_z[i]);
      3: return 16'(o_d[i]);
      4: return 16'(o_o[i]);
      default: return 16'(o_p[i]);
    endcase
  endfunction
  task automatic chk(input int i, input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s W=%0d cyc=%0d got=%0h want=%0h", nm, wd(i), cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk(i, "saida", o_s[i], e_s[i]);
      chk(i, "carry", 16'(o_c[i]), 16'(e_c[i]));
      chk(i, "zero", 16'(o_z[i]), 16'(e_z[i]));
      chk(i, "divzero", 16'(o_d[i]), 16'(e_d[i]));
      chk(i, "ocupado", 16'(o_o[i]), 16'(e_o[i]));
      chk(i, "pronto", 16'(o_p[i]), 16'(e_p[i]));
    end
    for (int p = 0; p < np; p++)
      if (pa[p] == cyc) chk(pi_[p], {"pin_", fname[pf[p]]}, getf(pi_[p], pf[p]), pv[p]);
  end
  task automatic issue(input int i, input logic [3:0] s, input logic [7:0] a, input logic [7:0] b, output int t);
    @(negedge clk);
    st[i] = 1'b1; sl[i] = s; av[i] = a; bv[i] = b;
    t = cyc;
    @(negedge clk);
    st[i] = 1'b0; av[i] = 8'($urandom); bv[i] = 8'($urandom);
  endtask
  task automatic b2b(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
    st[0] = 1'b1; sl[0] = s; av[0] = a; bv[0] = b;
    @(negedge clk);
    if ((s == 4'd2) || ((s == 4'd3) && (b != 8'd0))) begin
      sl[0] = 4'($urandom); av[0] = 8'($urandom); bv[0] = 8'($urandom);
      repeat (4) @(negedge clk);
    end
  endtask
  logic [7:0] corner[7] = '{8'd0, 8'd1, 8'd2, 8'd127, 8'd128, 8'd254, 8'd255};
  initial begin
    int t, cr;
    for (int i = 0; i < 2; i++) begin st[i] = 1'b0; sl[i] = '0; av[i] = '0; bv[i] = '0; end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    // reset in the middle of a multiply
    issue(0, 4'd2, 8'd15, 8'd15, t);
    @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    cr = cyc;
    pin(0, 4, 16'd0, cr); pin(0, 0, 16'd0, cr); pin(0, 2, 16'd1, cr); pin(0, 5, 16'd0, cr);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    issue(0, 4'd0, 8'd9, 8'd8, t);
    pin(0, 0, 16'd17, t + 2); pin(0, 1, 16'd1, t + 2); pin(0, 5, 16'd1, t + 2); pin(0, 5, 16'd0, t + 3);
    repeat (3) @(negedge clk);
    issue(0, 4'd1, 8'd3, 8'd5, t);
    pin(0, 0, 16'd14, t + 2); pin(0, 1, 16'd1, t + 2);
    issue(0, 4'd6, 8'd1, 8'd0, t);
    pin(0, 0, 16'd8, t + 2);
    issue(0, 4'd14, 8'd2, 8'd2, t);
    pin(0, 0, 16'd0, t + 2); pin(0, 2, 16'd1, t + 2);
    repeat (2) @(negedge clk);
    // multiply with a start pulse while busy that must be dropped
    issue(0, 4'd2, 8'd15, 8'd15, t);
    st[0] = 1'b1; sl[0] = 4'd0; av[0] = 8'd1; bv[0] = 8'd1;
    for (int k = 1; k <= 4; k++) pin(0, 4, 16'd1, t + k);
    pin(0, 0, 16'd225, t + 5); pin(0, 5, 16'd1, t + 5); pin(0, 4, 16'd0, t + 5);
    pin(0, 5, 16'd0, t + 6); pin(0, 5, 16'd0, t + 7);
    @(negedge clk);
    st[0] = 1'b0;
    repeat (7) @(negedge clk);
    issue(0, 4'd3, 8'd13, 8'd4, t);
    pin(0, 0, 16'h13, t + 5); pin(0, 5, 16'd1, t + 5);
    repeat (5) @(negedge clk);
    issue(0, 4'd3, 8'd7, 8'd0, t);
    pin(0, 0, 16'hFF, t + 2); pin(0, 3, 16'd1, t + 2); pin(0, 5, 16'd1, t + 2);
    issue(0, 4'd0, 8'd1, 8'd1, t);
    pin(0, 3, 16'd0, t + 2); pin(0, 0, 16'd2, t + 2);
    repeat (2) @(negedge clk);
    // exhaustive one-cycle ops, a new op accepted every cycle
    for (int s = 0; s < 16; s++) begin
      if (s == 2 || s == 3) continue;
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          st[0] = 1'b1; sl[0] = 4'(s); av[0] = 8'(a); bv[0] = 8'(b);
          @(negedge clk);
        end
    end
    st[0] = 1'b0;
    repeat (2) @(negedge clk);
    // exhaustive multiply/divide at W=4
    for (int s = 2; s < 4; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          issue(0, 4'(s), 8'(a), 8'(b), t);
          repeat (4) @(negedge clk);
        end
    // back-to-back with start held, operands scrambled after each acceptance
    @(negedge clk);
    b2b(4'd2, 8'd3, 8'd5);
    b2b(4'd0, 8'd15, 8'd1);
    b2b(4'd3, 8'd9, 8'd2);
    b2b(4'd1, 8'd2, 8'd9);
    b2b(4'd3, 8'd5, 8'd0);
    b2b(4'd2, 8'd0, 8'd7);
    b2b(4'd7, 8'd9, 8'd0);
    b2b(4'd3, 8'd15, 8'd15);
    b2b(4'd15, 8'd6, 8'd6);
    st[0] = 1'b0;
    repeat (6) @(negedge clk);
    // W=8 multiply/divide
    issue(1, 4'd2, 8'd255, 8'd255, t);
    pin(1, 4, 16'd1, t + 1); pin(1, 4, 16'd1, t + 8);
    pin(1, 0, 16'd65025, t + 9); pin(1, 5, 16'd1, t + 9); pin(1, 4, 16'd0, t + 9);
    repeat (9) @(negedge clk);
    issue(1, 4'd3, 8'd200, 8'd7, t);
    pin(1, 0, 16'h041C, t + 9); pin(1, 5, 16'd1, t + 9);
    repeat (9) @(negedge clk);
    for (int s = 2; s < 4; s++) begin
      for (int x = 0; x < 7; x++)
        for (int y = 0; y < 7; y++) begin
          issue(1, 4'(s), corner[x], corner[y], t);
          repeat (8) @(negedge clk);
        end
      for (int k = 0; k < 300; k++) begin
        issue(1, 4'(s), 8'($urandom), 8'($urandom), t);
        repeat (8) @(negedge clk);
      end
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
